// File: rtl/branch_pred.sv
// 16-entry direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational from if_pc; training, allocation and the mispredict counter update on posedge clk.
module branch_pred (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_branch,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_npc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] mispredict_cnt
);

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TAG_W   = 26;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned CNT_W   = 32;

    localparam logic [CTR_W-1:0] CTR_MAX   = 2'b11;
    localparam logic [CTR_W-1:0] CTR_MIN   = 2'b00;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             do_train;
    logic             do_inval;
    logic             do_alloc;
    logic             do_target;
    logic [CTR_W-1:0] ctr_next;

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    assign if_idx  = if_pc[5:2];
    assign if_tag  = if_pc[31:6];
    assign upd_idx = upd_pc[5:2];
    assign upd_tag = upd_pc[31:6];

    // Fetch-side lookup sees only committed state, so same-cycle updates appear next cycle.
    always_comb begin
        if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        if_pred_branch = if_hit;
        if_pred_taken  = if_hit && ctr_q[if_idx][1];
        if_pred_npc    = if_pred_taken ? target_q[if_idx] : (if_pc + ADDR_W'(4));
    end

    always_comb begin
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        do_train  = upd_en && upd_hit && upd_is_branch;
        do_inval  = upd_en && upd_hit && !upd_is_branch;
        do_alloc  = upd_en && !upd_hit && upd_is_branch && upd_taken;
        do_target = do_alloc || (do_train && upd_taken);
        ctr_next  = ctr_q[upd_idx];
        if (upd_taken) begin
            if (ctr_q[upd_idx] != CTR_MAX) ctr_next = ctr_q[upd_idx] + CTR_W'(1);
        end else begin
            if (ctr_q[upd_idx] != CTR_MIN) ctr_next = ctr_q[upd_idx] - CTR_W'(1);
        end
    end

    // Valid bits, counters and the mispredict count are the only reset state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
            cnt_q <= '0;
        end else begin
            if (do_alloc) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= CTR_ALLOC;
            end else if (do_train) begin
                ctr_q[upd_idx]   <= ctr_next;
            end else if (do_inval) begin
                valid_q[upd_idx] <= 1'b0;
            end
            if (upd_en && upd_mispredict && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Tag and target carry no reset; they are qualified by valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (do_alloc) tag_q[upd_idx] <= upd_tag;
            if (do_target) target_q[upd_idx] <= upd_target;
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_pred.sv
// Directed and random checks of branch_pred against a small table model kept in the bench.
module tb_branch_pred;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_branch;
    logic        if_pred_taken;
    logic [31:0] if_pred_npc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] mispredict_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per table slot, plain integers for the counter.
    bit          m_valid [16];
    bit   [25:0] m_tag   [16];
    bit   [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_cnt;

    branch_pred dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_branch (if_pred_branch),
        .if_pred_taken  (if_pred_taken),
        .if_pred_npc    (if_pred_npc),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_is_branch  (upd_is_branch),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic void m_look(input logic [31:0] pc, output logic b, output logic t,
                                   output logic [31:0] npc);
        int i;
        i   = int'(pc[5:2]);
        b   = m_valid[i] && (m_tag[i] == pc[31:6]);
        t   = b && (m_ctr[i] >= 2);
        npc = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    task automatic m_commit();
        int i;
        bit hit;
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_cnt = 32'd0;
        end else if (upd_en) begin
            if (upd_mispredict && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            i   = int'(upd_pc[5:2]);
            hit = m_valid[i] && (m_tag[i] == upd_pc[31:6]);
            if (hit && upd_is_branch) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (hit) begin
                m_valid[i] = 1'b0;
            end else if (upd_is_branch && upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = upd_pc[31:6];
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    endtask

    task automatic drive(input logic [31:0] p_pc, input logic p_en, input logic [31:0] p_upc,
                         input logic p_br, input logic p_tk, input logic [31:0] p_tgt,
                         input logic p_mp, input logic p_rst);
        if_pc          = p_pc;
        upd_en         = p_en;
        upd_pc         = p_upc;
        upd_is_branch  = p_br;
        upd_taken      = p_tk;
        upd_target     = p_tgt;
        upd_mispredict = p_mp;
        rst_n          = p_rst;
        #1;
    endtask

    task automatic check_model();
        logic b, t;
        logic [31:0] npc;
        m_look(if_pc, b, t, npc);
        check("model_branch", {31'd0, if_pred_branch}, {31'd0, b});
        check("model_taken",  {31'd0, if_pred_taken},  {31'd0, t});
        check("model_npc",    if_pred_npc, npc);
        check("model_cnt",    mispredict_cnt, m_cnt);
    endtask

    task automatic clock();
        @(posedge clk);
        m_commit();
        @(negedge clk);
    endtask

    task automatic step(input logic [31:0] p_pc, input logic p_en, input logic [31:0] p_upc,
                        input logic p_br, input logic p_tk, input logic [31:0] p_tgt,
                        input logic p_mp, input logic p_rst);
        drive(p_pc, p_en, p_upc, p_br, p_tk, p_tgt, p_mp, p_rst);
        check_model();
        clock();
    endtask

    task automatic expect_look(input string name, input logic b, input logic t, input logic [31:0] npc);
        check({name, "_branch"}, {31'd0, if_pred_branch}, {31'd0, b});
        check({name, "_taken"},  {31'd0, if_pred_taken},  {31'd0, t});
        check({name, "_npc"},    if_pred_npc, npc);
    endtask

    // Idle cycle that looks up pc and checks both the model and fixed expectations.
    task automatic look(input string name, input logic [31:0] pc, input logic b, input logic t,
                        input logic [31:0] npc);
        drive(pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check_model();
        expect_look(name, b, t, npc);
        clock();
    endtask

    localparam logic [25:0] TAGS [4] = '{26'h0010000, 26'h0010001, 26'h3FFFFFF, 26'h0000000};

    initial begin
        logic [31:0] rpc, rupc, rtgt;
        m_cnt = 32'd0;

        // Reset with a concurrent update that must be dropped.
        drive(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 1'b0);
        clock();
        drive(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 1'b0);
        check_model();
        expect_look("in_reset", 1'b0, 1'b0, 32'h0040_0014);
        check("reset_cnt", mispredict_cnt, 32'd0);
        clock();
        look("after_reset", 32'h0040_0000, 1'b0, 1'b0, 32'h0040_0004);

        // Allocation then hit.
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 1'b1);
        look("alloc_hit", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
        check("cnt_one", mispredict_cnt, 32'd1);

        // Counter walk: 10 -> 01 -> 00, floor, then climb and saturate.
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        look("ctr_00", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b1);
        look("ctr_floor", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b1);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0180, 1'b0, 1'b1);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0180, 1'b0, 1'b1);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        look("ctr_sat", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0180);

        // Alias at the same index with a different tag replaces the entry.
        look("alias_miss", 32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
        step(32'h0040_0000, 1'b1, 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b1);
        look("old_evicted", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        look("alias_hit", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);

        // Same-cycle lookup sees pre-update state.
        drive(32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300, 1'b0, 1'b1);
        check_model();
        expect_look("same_cycle", 1'b0, 1'b0, 32'h0040_0024);
        clock();
        look("next_cycle", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300);

        // Aliased non-branch invalidates; not-taken miss allocates nothing.
        step(32'h0040_0000, 1'b1, 32'h0040_0020, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        look("inval", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        step(32'h0040_0000, 1'b1, 32'h0040_0060, 1'b1, 1'b0, 32'h0040_0400, 1'b0, 1'b1);
        look("nt_miss", 32'h0040_0060, 1'b0, 1'b0, 32'h0040_0064);

        // Mispredict without upd_en is ignored; npc wraps at the top of the address space.
        step(32'h0040_0000, 1'b0, 32'h0040_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        check("cnt_no_en", mispredict_cnt, 32'd1);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Mid-sequence reset discards learned entries.
        step(32'h0040_0050, 1'b1, 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0500, 1'b1, 1'b0);
        look("reset_flush", 32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);

        // Random traffic over a small set of tags to force hits, aliases and evictions.
        for (int n = 0; n < 600; n++) begin
            rpc  = {TAGS[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            rupc = {TAGS[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'b00};
            rtgt = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = rupc;
            step(rpc, 1'($urandom_range(0, 3) != 0), rupc, 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 2) != 0), rtgt, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 60) != 0));
        end

        // Saturation of the mispredict counter from a preloaded value.
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int n = 0; n < 3; n++)
            step(32'h0040_0000, 1'b1, 32'h0040_0008, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        drive(32'h0040_0000, 1'b1, 32'h0040_0008, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        check_model();
        check("cnt_sat", mispredict_cnt, 32'hFFFF_FFFF);
        clock();
        drive(32'h0040_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        check_model();
        check("cnt_reset", mispredict_cnt, 32'd0);
        clock();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_pred.md
BRANCH_PRED -- requirements
Module: branch_pred

Interface
REQ-001 Clock/reset are fixed: one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 if_pc  in  32  fetch PC to look up.
REQ-005 if_pred_branch  out  1  BTB hit for if_pc.
REQ-006 if_pred_taken  out  1  hit and counter predicts taken.
REQ-007 if_pred_npc  out  32  predicted next PC.
REQ-008 upd_en  in  1  resolved control-flow instruction from ID, one update per cycle.
REQ-009 upd_pc  in  32  PC of the resolved instruction.
REQ-010 upd_is_branch  in  1  resolved instruction is a branch or jump.
REQ-011 upd_taken  in  1  actual direction.
REQ-012 upd_target  in  32  actual taken target.
REQ-013 upd_mispredict  in  1  ID detected a misprediction for upd_pc.
REQ-014 mispredict_cnt  out  32  saturating misprediction count.

Function
REQ-015 Table: 16 entries, direct-mapped; index = pc[5:2], tag = pc[31:6]; each entry holds valid, tag[25:0], target[31:0], ctr[1:0].
REQ-016 Lookup is combinational from if_pc and current table state; zero-cycle latency.
REQ-017 Hit = valid[idx] and tag[idx] == if_pc[31:6]; if_pred_branch = hit.
REQ-018 if_pred_taken = hit and ctr[idx][1].
REQ-019 if_pred_npc = target[idx] when if_pred_taken, else if_pc + 4 (32-bit modulo, 0xFFFFFFFC -> 0x00000000).
REQ-020 Updates commit on posedge clk only when upd_en = 1 and rst_n = 1.
REQ-021 Update hit with upd_is_branch = 1: ctr saturating increment if upd_taken (max 2'b11), saturating decrement otherwise (min 2'b00); target <= upd_target only if upd_taken.
REQ-022 Update miss with upd_is_branch = 1 and upd_taken = 1: allocate or replace the entry: valid = 1, tag = upd_pc[31:6], target = upd_target, ctr = 2'b10.
REQ-023 Update miss with upd_taken = 0: no table change.
REQ-024 Update hit with upd_is_branch = 0 (aliased non-branch): valid[idx] <= 0.
REQ-025 Same-cycle lookup and update to the same index: lookup returns pre-update state; the new state is visible from the next cycle.
REQ-026 mispredict_cnt increments by 1 on each cycle with upd_en = 1 and upd_mispredict = 1; it holds at 0xFFFFFFFF.
REQ-027 upd_mispredict has no effect when upd_en = 0.
REQ-028 Table and counter state change only at posedge clk; no other state exists.

Reset
REQ-029 With rst_n = 0 at posedge clk: all valid <= 0, all ctr <= 2'b01, mispredict_cnt <= 0; tag and target are don't-care.
REQ-030 Reset overrides any concurrent update; the update in that cycle is dropped.
REQ-031 During and after reset, if_pred_branch = 0, if_pred_taken = 0 and if_pred_npc = if_pc + 4 until an allocation occurs.
REQ-032 Reset asserted mid-sequence discards all learned entries; the next lookup of a previously hit PC misses.

Verification
REQ-033 After reset, if_pc = 0x00400000 -> if_pred_branch = 0, if_pred_taken = 0, if_pred_npc = 0x00400004.
REQ-034 Update upd_pc = 0x00400010, taken, target 0x00400100; next cycle if_pc = 0x00400010 -> branch = 1, taken = 1, npc = 0x00400100.
REQ-035 Same PC, then 2 not-taken updates -> ctr 10 -> 01 -> 00; lookup gives branch = 1, taken = 0, npc = 0x00400014; 3 taken updates -> ctr = 11; a 4th taken update keeps ctr = 11.
REQ-036 Alias: allocate 0x00400010, then look up 0x00400050 (same index, different tag) -> miss; a taken update at 0x00400050 replaces the entry, after which 0x00400010 misses.
REQ-037 Same cycle: if_pc = upd_pc = 0x00400020 on first allocation -> lookup misses that cycle and hits the next cycle.
REQ-038 Preload mispredict_cnt to 0xFFFFFFFE (force), apply 3 mispredict updates -> 0xFFFFFFFF then held; a mispredict concurrent with rst_n = 0 -> 0.
